// File: rtl/add_share_sched.sv
// rtl/add_share_sched.sv - round-robin scheduler sharing one 32-bit adder; SUB runs a + ~b then +1
// Optional ADD_SHARE_OVF_EN adds the registered signed-overflow flag rsp_ovf.

module adder32 (
   input  logic [31:0] i_x,
   input  logic [31:0] i_y,
   output logic [31:0] o_sum
);
   assign o_sum = i_x + i_y;
endmodule

module add_share_sched #(
   parameter int NREQ = 2,
   parameter int IDW  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ-1:0]    req_sub,
   input  logic [32*NREQ-1:0] req_a,
   input  logic [32*NREQ-1:0] req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [31:0]        rsp_data
`ifdef ADD_SHARE_OVF_EN
   ,
   output logic               rsp_ovf
`endif
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PASS1 = 2'd1;
   localparam logic [1:0] S_PASS2 = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]     r_state;
   logic [31:0]    r_op_a;
   logic [31:0]    r_op_b;
   logic [31:0]    r_acc;
   logic           r_op_sub;
   logic [IDW-1:0] r_op_id;
   logic [IDW-1:0] r_rr_ptr;

   logic           w_gnt_vld;
   logic [IDW-1:0] w_gnt_idx;
   logic [31:0]    w_gnt_a;
   logic [31:0]    w_gnt_b;
   logic           w_gnt_sub;
   logic [31:0]    w_x;
   logic [31:0]    w_y;
   logic [31:0]    w_sum;

   function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NREQ) s = s - NREQ;
      return s[IDW-1:0];
   endfunction

   // Scan from the farthest candidate down so the one nearest rr_ptr wins.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && (wrap_inc(r_rr_ptr, k) == IDW'(i))) begin
               w_gnt_vld = 1'b1;
               w_gnt_idx = IDW'(i);
            end
         end
      end
   end

   always_comb begin
      w_gnt_a   = '0;
      w_gnt_b   = '0;
      w_gnt_sub = 1'b0;
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt_idx == IDW'(i)) begin
            w_gnt_a      = req_a[32*i +: 32];
            w_gnt_b      = req_b[32*i +: 32];
            w_gnt_sub    = req_sub[i];
            req_ready[i] = w_gnt_vld && (r_state == S_IDLE) && !rst;
         end
      end
   end

   always_comb begin
      if (r_state == S_PASS2) begin
         w_x = r_acc;
         w_y = 32'd1;
      end else begin
         w_x = r_op_a;
         w_y = r_op_sub ? ~r_op_b : r_op_b;
      end
   end

   adder32 u_adder (
      .i_x   (w_x),
      .i_y   (w_y),
      .o_sum (w_sum)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_op_sub <= 1'b0;
         r_op_id  <= '0;
         r_acc    <= '0;
         r_rr_ptr <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_vld) begin
                  r_op_a   <= w_gnt_a;
                  r_op_b   <= w_gnt_b;
                  r_op_sub <= w_gnt_sub;
                  r_op_id  <= w_gnt_idx;
                  r_rr_ptr <= wrap_inc(w_gnt_idx, 1);
                  r_state  <= S_PASS1;
               end
            end
            S_PASS1: begin
               r_acc   <= w_sum;
               r_state <= r_op_sub ? S_PASS2 : S_HOLD;
            end
            S_PASS2: begin
               r_acc   <= w_sum;
               r_state <= S_HOLD;
            end
            default: begin
               if (rsp_ready) r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = (r_state == S_HOLD);
   assign rsp_id    = r_op_id;
   assign rsp_data  = r_acc;

`ifdef ADD_SHARE_OVF_EN
   logic r_ovf;
   logic w_ovf;

   // w_sum is the final result on whichever pass transitions into HOLD.
   assign w_ovf = r_op_sub ? ((r_op_a[31] != r_op_b[31]) && (w_sum[31] != r_op_a[31]))
                           : ((r_op_a[31] == r_op_b[31]) && (w_sum[31] != r_op_a[31]));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (((r_state == S_PASS1) && !r_op_sub) || (r_state == S_PASS2)) begin
         r_ovf <= w_ovf;
      end
   end

   assign rsp_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_add_share_sched.sv
// tb/tb_add_share_sched.sv - scoreboard bench for add_share_sched
// Expected results are pushed on accept and popped on each response handshake.

module tb_add_share_sched;
   localparam int NREQ = 2;
   localparam int IDW  = 2;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   req_sub;
   logic [32*NREQ-1:0] req_a;
   logic [32*NREQ-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [31:0]       rsp_data;
`ifdef ADD_SHARE_OVF_EN
   logic              rsp_ovf;
`endif

   add_share_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_sub   (req_sub),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
`ifdef ADD_SHARE_OVF_EN
      ,
      .rsp_ovf   (rsp_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [31:0]    data;
      logic           ovf;
   } exp_t;

   exp_t sb[$];
   exp_t obs;
   exp_t exp_q;
   int   n_vec = 0;
   int   n_err = 0;

   function automatic exp_t model(input int i);
      exp_t        e;
      logic [31:0] a;
      logic [31:0] b;
      a      = req_a[32*i +: 32];
      b      = req_b[32*i +: 32];
      e.id   = IDW'(i);
      e.data = req_sub[i] ? (a - b) : (a + b);
      e.ovf  = req_sub[i] ? ((a[31] ^ b[31]) & (e.data[31] ^ a[31]))
                          : (~(a[31] ^ b[31]) & (e.data[31] ^ a[31]));
      return e;
   endfunction

   // Called at a negedge after inputs are driven: samples what the next posedge will do.
   task automatic tick(output int g, output logic hs, output logic rv);
      #1;
      g = -1;
      for (int i = 0; i < NREQ; i++)
         if (req_ready[i]) g = (g == -1) ? i : -2;
      rv       = rsp_valid;
      hs       = rsp_valid && rsp_ready;
      obs.id   = rsp_id;
      obs.data = rsp_data;
`ifdef ADD_SHARE_OVF_EN
      obs.ovf  = rsp_ovf;
`else
      obs.ovf  = 1'b0;
`endif
      if (g >= 0) sb.push_back(model(g));
      @(negedge clk);
   endtask

   task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output int lat, output logic got, output logic one_cycle);
      int   g;
      int   t_acc;
      int   t_rv;
      logic hs;
      logic rv;
      got = 1'b0; one_cycle = 1'b0; t_acc = -1; t_rv = -1; lat = -1;
      req_valid[i] = 1'b1; req_a[32*i +: 32] = a; req_b[32*i +: 32] = b; req_sub[i] = sub;
      for (int t = 0; t < 20 && !got; t++) begin
         tick(g, hs, rv);
         if (g == i && t_acc < 0) begin
            t_acc = t;
            req_valid[i] = 1'b0;
         end
         if (rv && t_rv < 0) t_rv = t;
         if (hs) begin
            got   = 1'b1;
            exp_q = (sb.size() > 0) ? sb.pop_front() : 'x;
         end
      end
      req_valid[i] = 1'b0;
      if (got) begin
         lat = t_rv - t_acc;
         tick(g, hs, rv);
         one_cycle = !rv;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '0; req_sub = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
      n_vec++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
      n_vec++; if (rsp_id !== '0) begin n_err++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add();
      int lat; logic got; logic oc;
      issue(0, 32'h5, 32'h3, 1'b0, lat, got, oc);
      n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL add_timeout got %b want 1", got); end
      n_vec++; if (obs.data !== 32'h8) begin n_err++; $display("FAIL add_data got %h want 00000008", obs.data); end
      n_vec++; if (obs.id !== 2'd0) begin n_err++; $display("FAIL add_id got %0d want 0", obs.id); end
      n_vec++; if (lat !== 2) begin n_err++; $display("FAIL add_latency got %0d want 2", lat); end
      n_vec++; if (oc !== 1'b1) begin n_err++; $display("FAIL add_valid_one_cycle got %b want 1", oc); end
   endtask

   task automatic test_sub();
      int lat; logic got; logic oc;
      issue(1, 32'h0, 32'h1, 1'b1, lat, got, oc);
      n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL sub_timeout got %b want 1", got); end
      n_vec++; if (obs.data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sub_wrap_data got %h want ffffffff", obs.data); end
      n_vec++; if (obs.id !== 2'd1) begin n_err++; $display("FAIL sub_id got %0d want 1", obs.id); end
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL sub_latency got %0d want 3", lat); end
      issue(1, 32'h1234_5678, 32'h0, 1'b1, lat, got, oc);
      n_vec++; if (obs.data !== 32'h1234_5678) begin n_err++; $display("FAIL sub_b0_data got %h want 12345678", obs.data); end
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL sub_b0_latency got %0d want 3", lat); end
   endtask

   task automatic test_random_ops();
      int lat; logic got; logic oc; int i;
      for (int n = 0; n < 10; n++) begin
         i = $urandom_range(0, NREQ - 1);
         issue(i, $urandom, $urandom, 1'($urandom_range(0, 1)), lat, got, oc);
         n_vec++; if (got !== 1'b1 || obs.data !== exp_q.data || obs.id !== exp_q.id)
            begin n_err++; $display("FAIL rand_op%0d got %b/%h/%0d want 1/%h/%0d", n, got, obs.data, obs.id, exp_q.data, exp_q.id); end
`ifdef ADD_SHARE_OVF_EN
         n_vec++; if (obs.ovf !== exp_q.ovf) begin n_err++; $display("FAIL rand_ovf%0d got %b want %b", n, obs.ovf, exp_q.ovf); end
`endif
      end
   endtask

   task automatic test_round_robin();
      int ord[4]; int n_g; int n_r; int dbl; int g; logic hs; logic rv;
      rst = 1'b1; @(negedge clk); rst = 1'b0; sb.delete();
      n_g = 0; n_r = 0; dbl = 0; rsp_ready = 1'b1; req_sub = '0;
      req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom}; req_valid = '1;
      for (int t = 0; t < 40 && n_r < 4; t++) begin
         tick(g, hs, rv);
         if (g == -2) dbl++;
         if (g >= 0 && n_g < 4) begin
            ord[n_g] = g; n_g++;
            req_a[32*g +: 32] = $urandom; req_b[32*g +: 32] = $urandom;
            if (n_g == 4) req_valid = '0;
         end
         if (hs) begin
            exp_q = (sb.size() > 0) ? sb.pop_front() : 'x;
            n_r++;
            n_vec++; if (obs.id !== exp_q.id || obs.data !== exp_q.data)
               begin n_err++; $display("FAIL rr_rsp%0d got %0d/%h want %0d/%h", n_r, obs.id, obs.data, exp_q.id, exp_q.data); end
         end
      end
      req_valid = '0;
      n_vec++; if (n_r !== 4) begin n_err++; $display("FAIL rr_count got %0d want 4", n_r); end
      n_vec++; if (dbl !== 0) begin n_err++; $display("FAIL rr_double_grant got %0d want 0", dbl); end
      for (int k = 0; k < 4; k++) begin
         n_vec++; if (k < n_g && ord[k] !== (k % 2)) begin n_err++; $display("FAIL rr_order%0d got %0d want %0d", k, ord[k], k % 2); end
      end
   endtask

   task automatic test_backpressure();
      int g; logic hs; logic rv; exp_t held; exp_t f; int seen; logic done;
      rsp_ready = 1'b0; req_sub = '0; sb.delete();
      req_a[63:32] = $urandom; req_b[63:32] = $urandom; req_valid = 2'b10;
      seen = 0; rv = 1'b0;
      for (int t = 0; t < 10 && !rv; t++) begin
         tick(g, hs, rv);
         if (g == 1) begin
            req_valid = 2'b01; req_a[31:0] = $urandom; req_b[31:0] = $urandom;
         end
      end
      held = obs;
      f = (sb.size() > 0) ? sb[0] : 'x;
      n_vec++; if (rv !== 1'b1 || held.data !== f.data || held.id !== f.id)
         begin n_err++; $display("FAIL bp_first got %b/%h/%0d want 1/%h/%0d", rv, held.data, held.id, f.data, f.id); end
      for (int t = 0; t < 5; t++) begin
         tick(g, hs, rv);
         n_vec++; if (rv !== 1'b1 || obs.data !== held.data || obs.id !== held.id || g !== -1)
            begin n_err++; $display("FAIL bp_hold%0d got %b/%h/%0d/%0d want 1/%h/%0d/-1", t, rv, obs.data, obs.id, g, held.data, held.id); end
      end
      rsp_ready = 1'b1;
      tick(g, hs, rv);
      exp_q = (sb.size() > 0) ? sb.pop_front() : 'x;
      n_vec++; if (hs !== 1'b1 || obs.data !== exp_q.data || obs.id !== 2'd1)
         begin n_err++; $display("FAIL bp_handshake got %b/%h/%0d want 1/%h/1", hs, obs.data, obs.id, exp_q.data); end
      n_vec++; if (g !== -1) begin n_err++; $display("FAIL bp_grant_on_handshake got %0d want -1", g); end
      tick(g, hs, rv);
      n_vec++; if (g !== 0) begin n_err++; $display("FAIL bp_next_grant got %0d want 0", g); end
      req_valid = '0; done = 1'b0;
      for (int t = 0; t < 10 && !done; t++) begin
         tick(g, hs, rv);
         if (hs) begin
            done = 1'b1;
            exp_q = (sb.size() > 0) ? sb.pop_front() : 'x;
            n_vec++; if (obs.data !== exp_q.data || obs.id !== 2'd0)
               begin n_err++; $display("FAIL bp_second got %h/%0d want %h/0", obs.data, obs.id, exp_q.data); end
         end
      end
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL bp_second_timeout got %b want 1", done); end
   endtask

   task automatic test_reset_mid();
      int g; logic hs; logic rv; int n_rsp; logic acc;
      rsp_ready = 1'b1; sb.delete(); acc = 1'b0;
      req_a[31:0] = 32'h0000_0010; req_b[31:0] = 32'h0000_0004; req_sub = 2'b01; req_valid = 2'b01;
      for (int t = 0; t < 10 && !acc; t++) begin
         tick(g, hs, rv);
         if (g == 0) acc = 1'b1;
      end
      req_valid = '0;
      n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL rm_accept_timeout got %b want 1", acc); end
      tick(g, hs, rv);
      rst = 1'b1;
      #1;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rm_rsp_valid got %b want 0", rsp_valid); end
      n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL rm_req_ready got %b want 0", req_ready); end
      @(negedge clk);
      rst = 1'b0; sb.delete();
      req_sub = '0; req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom}; req_valid = 2'b11;
      tick(g, hs, rv);
      n_vec++; if (g !== 0) begin n_err++; $display("FAIL rm_rr_ptr_grant got %0d want 0", g); end
      req_valid = '0; n_rsp = 0;
      for (int t = 0; t < 8; t++) begin
         tick(g, hs, rv);
         if (hs) begin
            n_rsp++;
            exp_q = (sb.size() > 0) ? sb.pop_front() : 'x;
            n_vec++; if (obs.data !== exp_q.data || obs.id !== 2'd0)
               begin n_err++; $display("FAIL rm_after_data got %h/%0d want %h/0", obs.data, obs.id, exp_q.data); end
         end
      end
      n_vec++; if (n_rsp !== 1) begin n_err++; $display("FAIL rm_rsp_count got %0d want 1", n_rsp); end
   endtask

`ifdef ADD_SHARE_OVF_EN
   task automatic test_ovf();
      int lat; logic got; logic oc;
      issue(0, 32'h7FFF_FFFF, 32'h1, 1'b0, lat, got, oc);
      n_vec++; if (obs.data !== 32'h8000_0000 || obs.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_add got %h/%b want 80000000/1", obs.data, obs.ovf); end
      issue(1, 32'h8000_0000, 32'h1, 1'b1, lat, got, oc);
      n_vec++; if (obs.data !== 32'h7FFF_FFFF || obs.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sub got %h/%b want 7fffffff/1", obs.data, obs.ovf); end
      issue(0, 32'h5, 32'h3, 1'b1, lat, got, oc);
      n_vec++; if (obs.data !== 32'h2 || obs.ovf !== 1'b0) begin n_err++; $display("FAIL ovf_none got %h/%b want 00000002/0", obs.data, obs.ovf); end
   endtask
`endif

   initial begin
      rst = 1'b1; req_valid = '0; req_sub = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      test_reset();
      test_add();
      test_sub();
      test_random_ops();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
`ifdef ADD_SHARE_OVF_EN
      test_ovf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/add_share_sched.md
Name: add_share_sched

Overview:
- Time-shares one combinational 32-bit adder instance (adder32, carry-in tied 0) between NREQ requesters in the execute stage.
- Typical requesters: address generation, branch-target compute, the multi-cycle unit's accumulate step.
- Performs ADD in one adder pass and SUB in two passes: a + ~b, then +1.
- Round-robin grant, one operation in flight, registered response with valid/ready handshake.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- IDW, 2, width of the requester-id field on the response; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_sub  in  NREQ  per-requester op select: 1 = a-b, 0 = a+b.
- req_a  in  32*NREQ  operand A; requester i occupies bits [32i+31:32i].
- req_b  in  32*NREQ  operand B, packed the same way.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_data  out  32  sum or difference, modulo 2^32.

Behaviour:
- Datapath:
  - One adder instance. Input muxes (x, y) are selected by the FSM state.
  - Registers: op_a, op_b, op_sub, op_id, acc (32), rr_ptr (IDW).
- FSM states: IDLE, PASS1, PASS2, HOLD. Reset state is IDLE.
- IDLE:
  - Grant the first requester with req_valid set, searching from rr_ptr upward with wrap-around.
  - req_ready[g] = 1 combinationally, for the granted index g only. No grant means req_ready = 0.
  - On grant: latch a, b, sub, id = g; set rr_ptr = g+1, wrapping to 0 after NREQ-1; go to PASS1.
- PASS1:
  - Adder inputs are op_a and (op_sub ? ~op_b : op_b); acc <= adder sum.
  - op_sub = 0: go to HOLD. op_sub = 1: go to PASS2.
- PASS2:
  - Adder inputs are acc and 32'd1; acc <= sum; go to HOLD.
- HOLD:
  - rsp_valid = 1, rsp_data = acc, rsp_id = op_id.
  - On rsp_valid & rsp_ready: go to IDLE.
  - Otherwise hold; rsp_data and rsp_id stay stable while rsp_valid = 1 and rsp_ready = 0.
- Latency, accept edge to rsp_valid high: ADD 2 cycles, SUB 3 cycles.
- Minimum issue interval: ADD 3 cycles, SUB 4 cycles. No new grant is made in the same cycle as a response handshake.
- Arithmetic:
  - Results wrap modulo 2^32; there is no carry-out.
  - SUB with b = 0: ~0 + a = a-1, then +1 gives a, which is correct.
- Reset values:
  - state = IDLE, acc = 0, op_* = 0, rr_ptr = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, req_ready = 0.
- Reset asserted mid-operation: the operation is dropped with no response; rr_ptr returns to 0.
- Requester rules:
  - A requester must hold valid and operands stable until it sees ready.
  - Deasserting req_valid before grant is allowed; that requester is simply not granted.
- Simultaneous requests are resolved only by rr_ptr. A requester that is continuously valid is granted within NREQ grants.

Optional Feature:
- Macro: ADD_SHARE_OVF_EN.
- Defined:
  - Adds output port rsp_ovf (1 bit), registered and valid with rsp_valid, reset 0.
  - Meaning: signed overflow of the full operation.
  - ADD: a[31] == b[31] and result[31] != a[31].
  - SUB: a[31] != b[31] and result[31] != a[31].
  - Computed from op_a, op_b, op_sub and the final acc, and latched on entry to HOLD.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Single ADD, requester 0: a = 0x0000_0005, b = 0x0000_0003, rsp_ready = 1. Required: rsp_data = 0x0000_0008, rsp_id = 0, rsp_valid 2 cycles after accept, high for 1 cycle.
- SUB wrap, requester 1: a = 0x0000_0000, b = 0x0000_0001. Required: rsp_data = 0xFFFF_FFFF, rsp_id = 1, rsp_valid 3 cycles after accept. Also a = 0x1234_5678, b = 0 gives 0x1234_5678.
- Round-robin fairness: both requesters continuously valid with ADDs, NREQ = 2. Required: grants alternate 0,1,0,1; rsp_id matches the grant order; no double grant.
- Backpressure: rsp_ready held 0 for 5 cycles in HOLD. Required: rsp_valid stays 1 and rsp_data/rsp_id stay stable; req_ready stays 0 throughout; the next grant happens no earlier than the cycle after the handshake.
- Reset during PASS2 of a SUB. Required: immediately rsp_valid = 0, req_ready = 0, rr_ptr = 0; no response emitted; after reset release a new request from requester 0 completes normally.
- With ADD_SHARE_OVF_EN: 0x7FFF_FFFF + 1 gives rsp_data = 0x8000_0000, rsp_ovf = 1. 0x8000_0000 - 1 gives 0x7FFF_FFFF, rsp_ovf = 1. 5 - 3 gives rsp_ovf = 0.
